// File: rtl/multi_object_move_if.sv
// Control and position bundle between the frame-timing logic and the object mover.
// Combinational wiring only; no latency of its own.
// No backpressure: every signal is a level or a single-cycle pulse.
interface multi_object_move_if #(
  parameter int NUM_OBJ = 4
);
  logic                   startOfFrame;
  logic [NUM_OBJ-1:0]     enable;
  logic [NUM_OBJ-1:0]     respawn;
  logic [NUM_OBJ-1:0]     flipX;
  logic [NUM_OBJ-1:0]     flipY;
  logic [NUM_OBJ*11-1:0]  topLeftX;
  logic [NUM_OBJ*11-1:0]  topLeftY;
  logic                   busy;
  logic                   frameDone;
  logic                   overrun;

  modport master (
    output startOfFrame, enable, respawn, flipX, flipY,
    input  topLeftX, topLeftY, busy, frameDone, overrun
  );

  modport slave (
    input  startOfFrame, enable, respawn, flipX, flipY,
    output topLeftX, topLeftY, busy, frameDone, overrun
  );
endinterface

// File: rtl/multi_object_move.sv
// Fixed-point mover for NUM_OBJ objects: gravity, speed saturation, border bounce, respawn, flips.
// Object i is written at the end of cycle 1+i after startOfFrame; frameDone pulses in cycle NUM_OBJ+1.
// No backpressure: startOfFrame during a sweep is dropped and raises the sticky overrun flag.
module multi_object_move #(
  parameter int NUM_OBJ      = 4,
  parameter int FRAC_BITS    = 6,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int OBJ_W        = 32,
  parameter int OBJ_H        = 32,
  parameter int INIT_X       = 280,
  parameter int INIT_Y       = 185,
  parameter int SPACING_X    = 64,
  parameter int INIT_X_SPEED = 30,
  parameter int INIT_Y_SPEED = 20,
  parameter int Y_ACCEL      = 1,
  parameter int MAX_SPEED    = 1023
) (
  input  logic               clk,
  input  logic               reset,
  multi_object_move_if.slave bus
);

  localparam int PW = 11 + FRAC_BITS + 1;   // signed position width
  localparam int SW = 12;                   // signed speed width
  localparam int NW = PW + 1;               // headroom for position + speed
  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  localparam logic signed [NW-1:0] X_LIM = NW'((X_MAX - OBJ_W) << FRAC_BITS);
  localparam logic signed [NW-1:0] Y_LIM = NW'((Y_MAX - OBJ_H) << FRAC_BITS);
  localparam logic signed [13:0]   S_MAX = 14'(MAX_SPEED);
  localparam logic signed [13:0]   S_MIN = -S_MAX;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  logic signed [PW-1:0] posX [NUM_OBJ];
  logic signed [PW-1:0] posY [NUM_OBJ];
  logic signed [SW-1:0] spdX [NUM_OBJ];
  logic signed [SW-1:0] spdY [NUM_OBJ];

  logic [NUM_OBJ-1:0] respPend, flipXPend, flipYPend, flipXDly, flipYDly, slotHit;
  state_t             state;
  logic [IW-1:0]      idx;
  logic               busyR, doneR, overrunR;

  logic signed [SW-1:0] curSx, curSy, sy, newSx, newSy;
  logic signed [13:0]   syWide;
  logic signed [NW-1:0] nx, ny;
  logic signed [PW-1:0] newX, newY;

  function automatic logic signed [PW-1:0] initX(input int i);
    return PW'((INIT_X + i * SPACING_X) << FRAC_BITS);
  endfunction

  // Next position/speed of the object in the current slot (flips, gravity, saturation, bounce)
  always_comb begin
    slotHit = '0;
    if (state == SWEEP) slotHit[idx] = 1'b1;

    curSx = flipXPend[idx] ? -spdX[idx] : spdX[idx];
    curSy = flipYPend[idx] ? -spdY[idx] : spdY[idx];

    syWide = 14'(curSy) + 14'(Y_ACCEL);
    if (syWide > S_MAX)      sy = SW'(S_MAX);
    else if (syWide < S_MIN) sy = SW'(S_MIN);
    else                     sy = SW'(syWide);

    nx = NW'(posX[idx]) + NW'(curSx);
    ny = NW'(posY[idx]) + NW'(sy);

    if ((nx[NW-1] || nx == '0) && curSx[SW-1]) begin
      newX  = '0;
      newSx = -curSx;
    end else if (nx >= X_LIM && !curSx[SW-1] && curSx != '0) begin
      newX  = PW'(X_LIM);
      newSx = -curSx;
    end else begin
      newX  = PW'(nx);
      newSx = curSx;
    end

    if ((ny[NW-1] || ny == '0) && sy[SW-1]) begin
      newY  = '0;
      newSy = -sy;
    end else if (ny >= Y_LIM && !sy[SW-1] && sy != '0) begin
      newY  = PW'(Y_LIM);
      newSy = -sy;
    end else begin
      newY  = PW'(ny);
      newSy = sy;
    end

    // A frozen object keeps its position and speed, but flips still take effect
    if (!bus.enable[idx]) begin
      newX  = posX[idx];
      newY  = posY[idx];
      newSx = curSx;
      newSy = curSy;
    end
  end

  // Sweep FSM, request latching and per-slot register update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        posX[i] <= initX(i);
        posY[i] <= PW'(INIT_Y << FRAC_BITS);
        spdX[i] <= SW'(INIT_X_SPEED);
        spdY[i] <= SW'(INIT_Y_SPEED);
      end
      respPend  <= '0;
      flipXPend <= '0;
      flipYPend <= '0;
      flipXDly  <= '0;
      flipYDly  <= '0;
      state     <= IDLE;
      idx       <= '0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      overrunR  <= 1'b0;
    end else begin
      flipXDly <= bus.flipX;
      flipYDly <= bus.flipY;
      // Requests arriving during their own slot survive to the next frame
      respPend  <= (respPend  & ~slotHit) | bus.respawn;
      flipXPend <= (flipXPend & ~slotHit) | (bus.flipX & ~flipXDly);
      flipYPend <= (flipYPend & ~slotHit) | (bus.flipY & ~flipYDly);
      doneR     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.startOfFrame) begin
            state <= SWEEP;
            idx   <= '0;
            busyR <= 1'b1;
          end
        end
        SWEEP: begin
          if (bus.startOfFrame) overrunR <= 1'b1;
          if (respPend[idx]) begin
            posX[idx] <= initX(int'(idx));
            posY[idx] <= PW'(INIT_Y << FRAC_BITS);
            spdX[idx] <= SW'(INIT_X_SPEED);
            spdY[idx] <= SW'(INIT_Y_SPEED);
          end else begin
            posX[idx] <= newX;
            posY[idx] <= newY;
            spdX[idx] <= newSx;
            spdY[idx] <= newSy;
          end
          if (idx == IW'(NUM_OBJ - 1)) begin
            state <= DONE;
            busyR <= 1'b0;
            doneR <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (bus.startOfFrame) overrunR <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_out
    assign bus.topLeftX[11*g +: 11] = posX[g][FRAC_BITS +: 11];
    assign bus.topLeftY[11*g +: 11] = posY[g][FRAC_BITS +: 11];
  end

  assign bus.busy      = busyR;
  assign bus.frameDone = doneR;
  assign bus.overrun   = overrunR;

endmodule
